compare_unit: RTL
=================

# compare_unit

Parametrised, multi-cycle set-on-compare unit for the RISC datapath. It accepts two WIDTH-bit operands and a compare opcode through a valid/ready handshake. It scans the operands CHUNK bits at a time from the most-significant end and terminates early at the first differing chunk. It returns a zero-extended 0/1 result through a second valid/ready handshake. It serves SLT/SLTU/SEQ/SNE/SGE/SGEU in the execute stage, replacing the fixed 24-bit unsigned less-than compare.

## Interface
- WIDTH, 24, operand and result width.
- CHUNK, 8, bits compared per cycle; WIDTH must be a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  000 SLTU, 001 SLT, 010 SEQ, 011 SNE, 100 SGEU, 101 SGE, 110/111 illegal.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes result.
- res  out  WIDTH  result; bit 0 = condition, bits WIDTH-1:1 = 0.
- illegal  out  1  valid with res; high when latched op was 110/111.
- busy  out  1  high in SCAN or DONE.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, and op. For signed ops (SLT, SGE), invert the MSB of both latched operands at capture, so that an unsigned scan yields a signed order. Set chunk index idx=NCHUNK-1 and move to SCAN.
- SCAN: each cycle compare chunk idx of the latched operands.
  - Chunks differ: lt = (a_chunk < b_chunk); eq=0; go to DONE.
  - Chunks equal and idx==0: lt=0; eq=1; go to DONE.
  - Otherwise: idx decrements; stay in SCAN.
- Illegal op: the scan still runs, but on entering DONE res=0 and illegal=1.
- Result on entry to DONE, registered:
  - SLTU/SLT: lt.
  - SEQ: eq.
  - SNE: !eq.
  - SGEU/SGE: !lt.
- DONE: out_valid=1. res and illegal stay stable until out_valid&out_ready, then go to IDLE.
- Inputs a, b, and op are ignored outside IDLE.

## Timing
- Reset (synchronous, any state): state=IDLE, idx=0, res=0, illegal=0, out_valid=0, busy=0, in_ready=1 from the cycle after the reset edge.
- Reset mid-SCAN or mid-DONE abandons the operation. No out_valid is produced for it.
- Latency, acceptance edge to out_valid high: k cycles, where k is the number of chunks scanned (1..NCHUNK).
  - First chunk differs: 1 cycle.
  - Operands equal: NCHUNK cycles.
- Backpressure: out_valid held high with constant res for any number of cycles while out_ready=0.
- Result handshake edge returns to IDLE. The next acceptance can occur on the following edge, so at most one operation is in flight. Throughput is k+2 cycles per op with out_ready tied high.
- in_ready=0 throughout SCAN and DONE. in_valid then has no effect and need not be held.
- Arithmetic:
  - Chunk compare is CHUNK-bit unsigned.
  - Signed ordering comes only from MSB inversion at capture.
  - No other width extension is performed.
- Boundaries:
  - a=b=0 and a=b=all-ones both give eq after NCHUNK cycles.
  - CHUNK=WIDTH gives a fixed 1-cycle latency.
  - idx never wraps below 0.

## Test plan
- SLTU, a=0x000001, b=0xFFFFFF, out_ready=1: out_valid one cycle after acceptance, res=0x000001, illegal=0.
- Signed order, a=0x800000, b=0x7FFFFF:
  - SLT: res=0x000001.
  - SLTU: res=0x000000.
  - SGE: res=0x000000.
  - Each completes in 1 cycle.
- Equality scan, a=b=0x123456:
  - SEQ: res=1 after exactly 3 cycles.
  - SNE: res=0.
  - SGEU: res=1.
- Mid-chunk difference, a=0x12_34_55, b=0x12_34_56, SLTU: res=1 after 3 cycles. With b=0x12_35_00, res=1 after 2 cycles.
- Backpressure and in_valid ignore:
  - Hold out_ready=0 for 5 cycles: out_valid and res stay constant, in_ready=0, and in_valid pulses with new operands are ignored.
  - Raise out_ready: one handshake occurs, then IDLE with in_ready=1.
- Reset and illegal op:
  - Assert rst during SCAN: the next cycle is IDLE, out_valid=0, res=0, and no stale result appears.
  - Then issue op=3'b110, a=5, b=9: res=0, illegal=1.

Source files
------------

// File: rtl/compare_unit.sv
// compare_unit: multi-cycle set-on-compare (SLT/SLTU/SEQ/SNE/SGE/SGEU).
// Scans operands CHUNK bits per cycle from the MSB end and exits early.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b, op            operands and compare opcode
//   out_valid/out_ready result handshake (valid only in DONE)
//   res                 zero-extended 0/1 result
//   illegal             opcode 110/111 was latched
//   busy                high in SCAN or DONE
module compare_unit #(
   parameter int WIDTH = 24,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             illegal,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [2:0]       rop;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] ac;
   logic [CHUNK-1:0] bc;
   logic             lt;
   logic             eq;
   logic             last;
   logic             cond;
   logic             sgn;
   logic             op_lt;
   logic             op_eq;
   logic             op_ne;
   logic             op_ge;
   logic             bad;

   always_comb begin
      ac = '0;
      bc = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IW'(i)) begin
            ac = ra[i*CHUNK +: CHUNK];
            bc = rb[i*CHUNK +: CHUNK];
         end
      end
   end

   assign lt   = ac < bc;
   assign eq   = ac == bc;
   // Stop at the first differing chunk or after the lowest one.
   assign last = !eq || (idx == '0);

   assign op_lt = rop[2:1] == 2'b00;
   assign op_eq = rop == 3'b010;
   assign op_ne = rop == 3'b011;
   assign op_ge = rop[2:1] == 2'b10;
   assign bad   = rop[2:1] == 2'b11;

   always_comb begin
      cond = 1'b0;
      unique case (1'b1)
         op_lt:   cond = lt;
         op_eq:   cond = eq;
         op_ne:   cond = !eq;
         op_ge:   cond = !lt;
         default: cond = 1'b0;
      endcase
   end

   // Flipping both MSBs maps two's-complement order onto unsigned order.
   assign sgn = op[1:0] == 2'b01;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ra      <= '0;
         rb      <= '0;
         rop     <= '0;
         idx     <= '0;
         res     <= '0;
         illegal <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  ra    <= a ^ (sgn ? MSB : '0);
                  rb    <= b ^ (sgn ? MSB : '0);
                  rop   <= op;
                  idx   <= IW'(NCHUNK - 1);
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (last) begin
                  res     <= bad ? '0 : WIDTH'(cond);
                  illegal <= bad;
                  state   <= DONE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;

endmodule
